// File: rtl/cprv_stage_buffer.sv
// Elastic valid/ready buffer placed between cprv pipeline stages.
// Circular store of DEPTH payloads with flush, occupancy status and a high-water mark.
module cprv_stage_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 2,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  valid_up_i,
   output logic                  ready_up_o,
   input  logic [DATA_WIDTH-1:0] data_up_i,
   output logic                  valid_dn_o,
   input  logic                  ready_dn_i,
   output logic [DATA_WIDTH-1:0] data_dn_o,
   output logic [CW-1:0]         count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [CW-1:0]         hwm_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         hwm_q, hwm_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  full, empty, push, pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign full_o  = full;
   assign empty_o = empty;
   assign count_o = count_q;
   assign hwm_o   = hwm_q;

   // Readiness comes only from registered occupancy, so no ready/valid path crosses the buffer.
   assign ready_up_o = !full && !flush_i;
   assign valid_dn_o = !empty && !flush_i;
   assign push       = valid_up_i && ready_up_o;
   assign pop        = valid_dn_o && ready_dn_i;
   assign data_dn_o  = mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
      hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hwm_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hwm_q    <= hwm_d;
      end
   end

   // Entries are individual registers so reset can define the post-reset payload.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [DATA_WIDTH-1:0] entry_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               entry_q <= '0;
            end else if (push && (wr_ptr_q == AW'(gi))) begin
               entry_q <= data_up_i;
            end
         end
         assign mem[gi] = entry_q;
      end
   endgenerate

endmodule

// File: tb/tb_cprv_stage_buffer.sv
// Directed checks on a DEPTH=4 buffer and a randomised scoreboard run on a DEPTH=8 buffer.
module tb_cprv_stage_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DEPTH=4 instance for directed vectors
   logic       rst_a, flush_a, vu_a, rdy_a;
   logic [7:0] du_a, dd_a;
   logic       ru_a, vd_a, full_a, empty_a;
   logic [2:0] cnt_a, hwm_a;

   // DEPTH=8 instance for the random run
   logic       rst_b, flush_b, vu_b, rdy_b;
   logic [7:0] du_b, dd_b;
   logic       ru_b, vd_b, full_b, empty_b;
   logic [3:0] cnt_b, hwm_b;

   cprv_stage_buffer #(.DATA_WIDTH(8), .DEPTH(4)) u_dut_a (
      .clk(clk), .rst(rst_a), .flush_i(flush_a),
      .valid_up_i(vu_a), .ready_up_o(ru_a), .data_up_i(du_a),
      .valid_dn_o(vd_a), .ready_dn_i(rdy_a), .data_dn_o(dd_a),
      .count_o(cnt_a), .full_o(full_a), .empty_o(empty_a), .hwm_o(hwm_a)
   );

   cprv_stage_buffer #(.DATA_WIDTH(8), .DEPTH(8)) u_dut_b (
      .clk(clk), .rst(rst_b), .flush_i(flush_b),
      .valid_up_i(vu_b), .ready_up_o(ru_b), .data_up_i(du_b),
      .valid_dn_o(vd_b), .ready_dn_i(rdy_b), .data_dn_o(dd_b),
      .count_o(cnt_b), .full_o(full_b), .empty_o(empty_b), .hwm_o(hwm_b)
   );

   int total = 0;
   int bad   = 0;
   bit verbose = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else if (verbose) begin
         $display("check %s ok: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] sb_q[$];
   logic [7:0] exp_d, stall_d;
   bit         stall_p;
   bit         do_push, do_pop;

   initial begin
      rst_a = 1'b1; flush_a = 1'b0; vu_a = 1'b0; rdy_a = 1'b0; du_a = 8'h00;
      rst_b = 1'b1; flush_b = 1'b0; vu_b = 1'b0; rdy_b = 1'b0; du_b = 8'h00;
      tick(); tick();
      rst_a = 1'b0;

      chk("rst_ready", 32'(ru_a), 32'd1);
      chk("rst_valid", 32'(vd_a), 32'd0);
      chk("rst_data", 32'(dd_a), 32'h00);
      chk("rst_count", 32'(cnt_a), 32'd0);
      chk("rst_full", 32'(full_a), 32'd0);
      chk("rst_empty", 32'(empty_a), 32'd1);
      chk("rst_hwm", 32'(hwm_a), 32'd0);

      // Fill to DEPTH with downstream stalled
      vu_a = 1'b1; rdy_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         du_a = 8'(8'h11 * (i + 1));
         tick();
      end
      chk("fill_full", 32'(full_a), 32'd1);
      chk("fill_ready", 32'(ru_a), 32'd0);
      chk("fill_count", 32'(cnt_a), 32'd4);
      chk("fill_hwm", 32'(hwm_a), 32'd4);
      chk("fill_head", 32'(dd_a), 32'h11);

      du_a = 8'h55;
      tick();
      chk("refuse_count", 32'(cnt_a), 32'd4);
      chk("refuse_head", 32'(dd_a), 32'h11);

      // Full with pop and push offered together: only the pop completes
      rdy_a = 1'b1;
      tick();
      chk("fullpop_count", 32'(cnt_a), 32'd3);
      chk("fullpop_head", 32'(dd_a), 32'h22);
      chk("fullpop_ready", 32'(ru_a), 32'd1);
      tick();
      chk("pushpop_count", 32'(cnt_a), 32'd3);
      chk("pushpop_head", 32'(dd_a), 32'h33);
      vu_a = 1'b0;
      tick();
      chk("drain_head44", 32'(dd_a), 32'h44);
      chk("drain_count2", 32'(cnt_a), 32'd2);
      tick();
      chk("drain_head55", 32'(dd_a), 32'h55);
      chk("drain_count1", 32'(cnt_a), 32'd1);
      tick();
      chk("drain_empty", 32'(empty_a), 32'd1);
      chk("drain_valid", 32'(vd_a), 32'd0);
      chk("drain_hwm", 32'(hwm_a), 32'd4);

      // Streaming across pointer wrap
      vu_a = 1'b1; rdy_a = 1'b1;
      for (int i = 0; i < 10; i++) begin
         du_a = 8'(i);
         tick();
         chk($sformatf("stream_valid%0d", i), 32'(vd_a), 32'd1);
         chk($sformatf("stream_data%0d", i), 32'(dd_a), 32'(i));
         chk($sformatf("stream_count%0d", i), 32'(cnt_a), 32'd1);
      end
      vu_a = 1'b0;
      tick();
      chk("stream_end_empty", 32'(empty_a), 32'd1);

      // Flush with three entries held
      rst_a = 1'b1; tick(); rst_a = 1'b0;
      vu_a = 1'b1; rdy_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         du_a = 8'(8'hA1 + i);
         tick();
      end
      chk("preflush_count", 32'(cnt_a), 32'd3);
      flush_a = 1'b1; du_a = 8'h99; rdy_a = 1'b1;
      #1;
      chk("flush_valid", 32'(vd_a), 32'd0);
      chk("flush_ready", 32'(ru_a), 32'd0);
      tick();
      flush_a = 1'b0; vu_a = 1'b0; rdy_a = 1'b0;
      #1;
      chk("postflush_count", 32'(cnt_a), 32'd0);
      chk("postflush_empty", 32'(empty_a), 32'd1);
      chk("postflush_hwm", 32'(hwm_a), 32'd3);
      vu_a = 1'b1; du_a = 8'hAB;
      tick();
      vu_a = 1'b0;
      chk("postflush_valid", 32'(vd_a), 32'd1);
      chk("postflush_data", 32'(dd_a), 32'hAB);
      chk("postflush_cnt1", 32'(cnt_a), 32'd1);

      // Reset while two entries held and a push is in flight
      vu_a = 1'b1; du_a = 8'hCD;
      tick();
      chk("prerst_count", 32'(cnt_a), 32'd2);
      rst_a = 1'b1; du_a = 8'hEE;
      tick();
      rst_a = 1'b0; vu_a = 1'b0;
      #1;
      chk("midrst_count", 32'(cnt_a), 32'd0);
      chk("midrst_data", 32'(dd_a), 32'h00);
      chk("midrst_hwm", 32'(hwm_a), 32'd0);
      chk("midrst_empty", 32'(empty_a), 32'd1);
      chk("midrst_ready", 32'(ru_a), 32'd1);
      chk("midrst_valid", 32'(vd_a), 32'd0);

      // Random valid/ready against a queue scoreboard
      verbose = 1'b0;
      rst_b = 1'b0;
      stall_p = 1'b0;
      stall_d = 8'h00;
      for (int c = 0; c < 10000; c++) begin
         tick();
         if (cnt_b !== 4'(sb_q.size())) begin
            chk("rnd_count", 32'(cnt_b), 32'(sb_q.size()));
         end
         vu_b  = 1'($urandom_range(0, 1));
         rdy_b = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
         if (c % 2000 > 1000) rdy_b = 1'($urandom_range(0, 1));
         du_b  = 8'($urandom);
         #1;
         do_push = vu_b && ru_b;
         do_pop  = vd_b && rdy_b;
         if (stall_p && vd_b) begin
            if (dd_b !== stall_d) chk("rnd_stall", 32'(dd_b), 32'(stall_d));
         end
         stall_p = vd_b && !rdy_b;
         stall_d = dd_b;
         if (do_pop) begin
            if (sb_q.size() == 0) begin
               chk("rnd_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
               exp_d = sb_q.pop_front();
               chk("rnd_data", 32'(dd_b), 32'(exp_d));
            end
         end
         if (do_push) sb_q.push_back(du_b);
      end
      vu_b = 1'b0; rdy_b = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (vd_b) begin
            if (sb_q.size() == 0) begin
               chk("drain_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
               exp_d = sb_q.pop_front();
               chk("rnd_drain", 32'(dd_b), 32'(exp_d));
            end
         end
      end
      verbose = 1'b1;
      chk("rnd_final_count", 32'(cnt_b), 32'd0);
      chk("rnd_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cprv_stage_buffer.md
# cprv_stage_buffer

Parametrised elastic buffer inserted between any two pipeline stages of the cprv core (IF→ID, ID→EX, EX→MEM, MEM→WB). It carries one opaque stage payload per entry under a valid/ready handshake and holds up to DEPTH entries in a circular store. It adds a pipeline flush for branch/exception redirect, occupancy status, and a high-water mark for performance tuning. No combinational path exists from ready_dn_i to ready_up_o or from valid_up_i to valid_dn_o.

## Interface
- DATA_WIDTH, 64, payload width in bits (stage bundle packed by the instantiating stage); ≥1
- DEPTH, 2, number of entries; power of two, ≥2
- CW (localparam), $clog2(DEPTH+1), width of count and high-water outputs
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all buffered entries
- valid_up_i  in  1  upstream payload valid
- ready_up_o  out  1  buffer can accept a payload this cycle
- data_up_i  in  DATA_WIDTH  upstream payload
- valid_dn_o  out  1  head entry valid toward downstream
- ready_dn_i  in  1  downstream accepts the head entry
- data_dn_o  out  DATA_WIDTH  head entry payload
- count_o  out  CW  current number of stored entries
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- hwm_o  out  CW  maximum count_o reached since reset

## Operation
- State: storage mem[DEPTH], wr_ptr and rd_ptr (log2(DEPTH) bits each, wrap modulo DEPTH naturally), count (CW bits), hwm (CW bits).
- ready_up_o = !full && !flush_i; valid_dn_o = !empty && !flush_i; data_dn_o = mem[rd_ptr].
- push = valid_up_i && ready_up_o: mem[wr_ptr] ← data_up_i, wr_ptr+1.
- pop = valid_dn_o && ready_dn_i: rd_ptr+1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: ready_up_o=0; a pop in the same cycle does not enable a push (no pass-through); slot is visible on the next cycle.
- Empty: valid_dn_o=0; a push in the same cycle is not bypassed to data_dn_o.
- Simultaneous push and pop with 0<count<DEPTH: both happen, count unchanged, pointers both advance.
- flush_i=1: no handshake completes on either side (both readies/valids forced low); next cycle wr_ptr=rd_ptr=0, count=0. Storage contents and hwm are not cleared.
- hwm ← max(hwm, next count) every cycle; saturates at DEPTH.
- rst has priority over flush_i and handshakes; asserting rst mid-transfer discards all entries and the in-flight handshake.

## Timing
- Reset values (cycle after rst sampled high): ready_up_o=1, valid_dn_o=0, data_dn_o=0 (all mem entries cleared to 0), count_o=0, full_o=0, empty_o=1, hwm_o=0, pointers 0.
- Latency: payload pushed at edge N is presented on data_dn_o with valid_dn_o=1 after edge N (one-cycle minimum).
- Throughput: one push and one pop per cycle when 0<count<DEPTH; DEPTH=2 sustains full rate across a single-cycle downstream stall.
- ready_up_o, full_o, empty_o, count_o, hwm_o depend only on registers (ready_up_o/valid_dn_o additionally on flush_i).
- data_dn_o is stable while valid_dn_o=1 and ready_dn_i=0 (no flush).
- Payload is don't-care while valid_dn_o=0, except the defined post-reset value.

## Test plan
- DEPTH=4: after rst, push 0x11,0x22,0x33,0x44 with ready_dn_i=0 → full_o=1, ready_up_o=0, count_o=4, hwm_o=4; fifth valid_up_i (0x55) not accepted; then ready_dn_i=1 → pops 0x11..0x44 in order, empty_o=1, 0x55 accepted only once a slot is free.
- Continuous streaming with ready_dn_i=1, push 0x0..0x9 back-to-back → one output per cycle, first output 1 cycle after first push, order preserved across pointer wrap, count_o never exceeds 1.
- Full + ready_dn_i=1 + valid_up_i=1 same cycle → pop occurs, push refused, count_o 4→3; next cycle push accepted, count_o 3→3 with pop.
- 3 entries held, flush_i pulsed with valid_up_i=1 and ready_dn_i=1 → valid_dn_o=0 and ready_up_o=0 during flush; next cycle count_o=0, empty_o=1, hwm_o unchanged (3); subsequent push 0xAB emerges first.
- rst asserted while count_o=2 and push active → next cycle all reset values, data_dn_o=0, hwm_o=0.
- Random valid/ready toggling, DATA_WIDTH=8, DEPTH=8, 10k cycles → output sequence equals accepted input sequence, no loss/duplication, data_dn_o stable under stall.
